// File: rtl/kd_sort_sched_pkg.sv
// Shared definitions for the kd-tree CE sequencer and the CE array:
// controller states, mode encodings and axis width/wrap helpers.
package kd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EVEN = 3'd1,
    ST_ODD  = 3'd2,
    ST_PROP = 3'd3,
    ST_DONE = 3'd4
  } kd_state_e;

  localparam logic MODE_SORT  = 1'b0;
  localparam logic MODE_QUERY = 1'b1;

  // Axis field width for a given dimensionality (at least one bit).
  function automatic int kd_axw(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  // Axis used 'off' levels below a node split on 'base'; base is < dim.
  function automatic int axis_wrap(input int base, input int off, input int dim);
    return (base + off) % dim;
  endfunction

endpackage

// File: rtl/kd_sort_sched_axis_map.sv
// Combinational per-row axis generator: row l splits on (axis_base + l) mod DIM.
module kd_axis_map
  import kd_pkg::*;
#(
  parameter int LEVELS = 4,
  parameter int DIM    = 3,
  parameter int AXW    = kd_axw(DIM)
) (
  input  logic [AXW-1:0]        axis_base,
  output logic [LEVELS*AXW-1:0] level_axis
);

  for (genvar l = 0; l < LEVELS; l++) begin : g_row
    assign level_axis[l*AXW +: AXW] = AXW'(axis_wrap(int'(axis_base), l, DIM));
  end

endmodule

// File: rtl/kd_sort_sched.sv
// Sequencer for the kd-tree CE array: even/odd sort sweeps until stable, or a
// root-to-leaf propagation walk. Optional sweep limit: KD_SORT_TIMEOUT_EN.
module kd_sort_sched
  import kd_pkg::*;
#(
  parameter int LEVELS     = 4,
  parameter int DIM        = 3,
  parameter int MAX_SWEEPS = 64,
  localparam int AXW       = kd_axw(DIM),
  localparam int SCW       = $clog2(MAX_SWEEPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [AXW-1:0]        axis_base,
  input  logic [LEVELS-1:0]     stable_in,
  output logic [LEVELS-1:0]     ce_en,
  output logic                  sorting,
  output logic                  point_prop,
  output logic [LEVELS*AXW-1:0] level_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [SCW-1:0]        sweep_count
);

  localparam int LVW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  function automatic logic [LEVELS-1:0] row_mask(input bit odd_rows);
    logic [LEVELS-1:0] m;
    for (int i = 0; i < LEVELS; i++) m[i] = ((i % 2) == 1) == odd_rows;
    return m;
  endfunction

  localparam logic [LEVELS-1:0] EVEN_MASK = row_mask(1'b0);
  localparam logic [LEVELS-1:0] ODD_MASK  = row_mask(1'b1);

  kd_state_e               state_q;
  logic [LVW-1:0]          lvl_q;
  logic                    dirty_q;
  logic [SCW-1:0]          sweep_q;
  logic [LEVELS*AXW-1:0]   axis_q;
  logic [LEVELS*AXW-1:0]   axis_map;
  logic [LEVELS-1:0]       ce_mask;
  logic                    dirty_next;
  logic [SCW-1:0]          sweep_inc;

  kd_axis_map #(.LEVELS(LEVELS), .DIM(DIM), .AXW(AXW)) u_axis_map (
    .axis_base  (axis_base),
    .level_axis (axis_map)
  );

  always_comb begin
    ce_mask = '0;
    case (state_q)
      ST_EVEN: ce_mask = EVEN_MASK;
      ST_ODD:  ce_mask = ODD_MASK;
      ST_PROP: ce_mask = LEVELS'(1) << lvl_q;
      default: ce_mask = '0;
    endcase
  end

  // stable_in only feeds state, never an output directly.
  assign dirty_next = dirty_q | (|(ce_mask & ~stable_in));
  assign sweep_inc  = (&sweep_q) ? sweep_q : sweep_q + SCW'(1);

`ifdef KD_SORT_TIMEOUT_EN
  logic timeout_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      dirty_q <= 1'b0;
      sweep_q <= '0;
      axis_q  <= '0;
`ifdef KD_SORT_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            axis_q  <= axis_map;
            sweep_q <= '0;
            dirty_q <= 1'b0;
            lvl_q   <= '0;
`ifdef KD_SORT_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            state_q <= (mode == MODE_QUERY) ? ST_PROP : ST_EVEN;
          end
        end
        ST_EVEN: begin
          dirty_q <= dirty_next;
          state_q <= ST_ODD;
        end
        ST_ODD: begin
          sweep_q <= sweep_inc;
          if (!dirty_next) begin
            dirty_q <= 1'b0;
            state_q <= ST_DONE;
          end
`ifdef KD_SORT_TIMEOUT_EN
          else if (sweep_inc == SCW'(MAX_SWEEPS)) begin
            dirty_q   <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end
`endif
          else begin
            dirty_q <= 1'b0;
            state_q <= ST_EVEN;
          end
        end
        ST_PROP: begin
          if (lvl_q == LVW'(LEVELS - 1)) state_q <= ST_DONE;
          else                           lvl_q   <= lvl_q + LVW'(1);
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ce_en       = ce_mask;
  assign sorting     = (state_q == ST_EVEN) || (state_q == ST_ODD);
  assign point_prop  = (state_q == ST_PROP);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign level_axis  = axis_q;
  assign sweep_count = sweep_q;
`ifdef KD_SORT_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_kd_sort_sched.sv
// Directed bench for kd_sort_sched (LEVELS=4, DIM=3, MAX_SWEEPS=4).
module tb_kd_sort_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] axis_base = 2'd0;
  logic [3:0] stable_in = 4'hF;
  logic [3:0] ce_en;
  logic       sorting, point_prop, busy, done, timeout;
  logic [7:0] level_axis;
  logic [2:0] sweep_count;

  int n_checks = 0;
  int n_fail   = 0;

  kd_sort_sched #(.LEVELS(4), .DIM(3), .MAX_SWEEPS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .axis_base   (axis_base),
    .stable_in   (stable_in),
    .ce_en       (ce_en),
    .sorting     (sorting),
    .point_prop  (point_prop),
    .level_axis  (level_axis),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .sweep_count (sweep_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_checks++;
    if ({ce_en, sorting, point_prop, busy, done, timeout, sweep_count, level_axis} !== 20'h0) begin
      $display("FAIL reset_outputs: got %h expected 0",
               {ce_en, sorting, point_prop, busy, done, timeout, sweep_count, level_axis});
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle: busy got %b expected 0", busy);
      n_fail++;
    end
  endtask

  task automatic test_converged();
    stable_in = 4'hF; mode = 1'b0; axis_base = 2'd0; start = 1'b1;
    tick(); start = 1'b0;
    n_checks++;
    if ({ce_en, sorting, point_prop, busy, done} !== {4'b0101, 4'b1010}) begin
      $display("FAIL conv_c1: ce/sort/prop/busy/done got %b expected 01011010",
               {ce_en, sorting, point_prop, busy, done});
      n_fail++;
    end
    tick();
    n_checks++;
    if ({ce_en, sorting, done} !== {4'b1010, 2'b10}) begin
      $display("FAIL conv_c2: ce/sort/done got %b expected 101010", {ce_en, sorting, done});
      n_fail++;
    end
    tick();
    n_checks++;
    if ({ce_en, sorting, done, timeout, sweep_count} !== {4'b0000, 3'b010, 3'd1}) begin
      $display("FAIL conv_done: ce/sort/done/to/sweeps got %b expected 0000010001",
               {ce_en, sorting, done, timeout, sweep_count});
      n_fail++;
    end
    tick();
    n_checks++;
    if ({busy, done, sweep_count} !== {2'b00, 3'd1}) begin
      $display("FAIL conv_idle: busy/done/sweeps got %b expected 00001", {busy, done, sweep_count});
      n_fail++;
    end
  endtask

  task automatic test_two_sweeps();
    logic [3:0] exp_ce [4] = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
    stable_in = 4'hF; mode = 1'b0; axis_base = 2'd0; start = 1'b1;
    tick(); start = 1'b0;
    stable_in = 4'b1011;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (ce_en !== exp_ce[c-1] || done !== 1'b0) begin
        $display("FAIL two_sweep_ce c%0d: ce/done got %b/%b expected %b/0", c, ce_en, done, exp_ce[c-1]);
        n_fail++;
      end
      tick();
      stable_in = 4'hF;
    end
    n_checks++;
    if ({done, sweep_count, level_axis} !== {1'b1, 3'd2, 8'h24}) begin
      $display("FAIL two_sweep_done: done/sweeps/axis got %b/%0d/%h expected 1/2/24",
               done, sweep_count, level_axis);
      n_fail++;
    end
    tick();
    // Row 1 unstable during EVEN is not enabled there; must not dirty the sweep.
    start = 1'b1;
    tick(); start = 1'b0;
    stable_in = 4'b1101;
    tick();
    stable_in = 4'hF;
    tick();
    n_checks++;
    if ({done, sweep_count} !== {1'b1, 3'd1}) begin
      $display("FAIL even_ignores_odd_row: done/sweeps got %b/%0d expected 1/1", done, sweep_count);
      n_fail++;
    end
    tick();
    // Row 1 unstable during ODD forces a second sweep.
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    stable_in = 4'b1101;
    tick();
    stable_in = 4'hF;
    n_checks++;
    if ({ce_en, done} !== {4'b0101, 1'b0}) begin
      $display("FAIL odd_dirty_resweep: ce/done got %b/%b expected 0101/0", ce_en, done);
      n_fail++;
    end
    tick(); tick();
    n_checks++;
    if ({done, sweep_count} !== {1'b1, 3'd2}) begin
      $display("FAIL odd_dirty_done: done/sweeps got %b/%0d expected 1/2", done, sweep_count);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_axis_map();
    stable_in = 4'hF; mode = 1'b0; axis_base = 2'd2; start = 1'b1;
    tick(); start = 1'b0;
    axis_base = 2'd1;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (level_axis !== 8'h92) begin
        $display("FAIL axis_map c%0d: level_axis got %h expected 92", c, level_axis);
        n_fail++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    stable_in = 4'hF; mode = 1'b0; axis_base = 2'd2; start = 1'b1;
    tick(); start = 1'b0;
    n_checks++;
    if ({ce_en, busy, level_axis} !== {4'b0101, 1'b1, 8'h92}) begin
      $display("FAIL pre_reset: ce/busy/axis got %b/%b/%h expected 0101/1/92", ce_en, busy, level_axis);
      n_fail++;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ce_en, sorting, point_prop, busy, done, timeout, sweep_count, level_axis} !== 20'h0) begin
      $display("FAIL reset_mid: got %h expected 0",
               {ce_en, sorting, point_prop, busy, done, timeout, sweep_count, level_axis});
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        $display("FAIL reset_mid_idle c%0d: busy/done got %b expected 00", c, {busy, done});
        n_fail++;
      end
    end
  endtask

  task automatic test_query();
    logic [3:0] exp_ce [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    stable_in = 4'h0; mode = 1'b1; axis_base = 2'd0; start = 1'b1;
    tick(); start = 1'b0; mode = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      start = (c == 2);
      n_checks++;
      if ({ce_en, point_prop, sorting, done, sweep_count} !== {exp_ce[c-1], 3'b100, 3'd0}) begin
        $display("FAIL query c%0d: ce/prop/sort/done/sweeps got %b expected %b",
                 c, {ce_en, point_prop, sorting, done, sweep_count}, {exp_ce[c-1], 3'b100, 3'd0});
        n_fail++;
      end
      tick();
    end
    start = 1'b0;
    n_checks++;
    if ({done, ce_en, point_prop} !== {1'b1, 4'b0000, 1'b0}) begin
      $display("FAIL query_done: done/ce/prop got %b expected 100000", {done, ce_en, point_prop});
      n_fail++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    stable_in = 4'hF; mode = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL b2b_done: done got %b expected 1", done);
      n_fail++;
    end
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL b2b_gap: busy/done got %b expected 00", {busy, done});
      n_fail++;
    end
    tick(); start = 1'b0;
    n_checks++;
    if ({ce_en, busy} !== {4'b0101, 1'b1}) begin
      $display("FAIL b2b_restart: ce/busy got %b expected 01011", {ce_en, busy});
      n_fail++;
    end
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    int cyc;
    logic saw_done;
    stable_in = 4'h0; mode = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    cyc = 1;
    saw_done = 1'b0;
`ifdef KD_SORT_TIMEOUT_EN
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if ({done, timeout, sweep_count} !== {2'b11, 3'd4} || cyc != 9) begin
      $display("FAIL timeout_done: done/to/sweeps/cycle got %b/%b/%0d/%0d expected 1/1/4/9",
               done, timeout, sweep_count, cyc);
      n_fail++;
    end
    tick();
    n_checks++;
    if ({busy, timeout} !== 2'b01) begin
      $display("FAIL timeout_hold: busy/to got %b expected 01", {busy, timeout});
      n_fail++;
    end
`else
    while (cyc < 100) begin
      tick();
      cyc++;
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if ({busy, timeout, saw_done, sweep_count} !== {3'b100, 3'd7}) begin
      $display("FAIL no_limit_c100: busy/to/done_seen/sweeps got %b/%b/%b/%0d expected 1/0/0/7",
               busy, timeout, saw_done, sweep_count);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, done, sweep_count} !== 5'b0) begin
      $display("FAIL no_limit_abort: busy/done/sweeps got %b expected 00000", {busy, done, sweep_count});
      n_fail++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_converged();
    test_two_sweeps();
    test_axis_map();
    test_reset_mid();
    test_query();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
